// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: load-use, branch-flush and data-memory stall control for a 5-stage pipeline
module pipeline_hazard_controller #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ID_EXE_MemRead,
  input  logic [4:0]       ID_EXE_rd,
  input  logic [4:0]       IF_ID_rs1,
  input  logic [4:0]       IF_ID_rs2,
  input  logic [6:0]       IF_ID_OPCODE,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EXE_Bubble,
  output logic             pipe_hold,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic             mem_timeout
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  typedef enum logic [1:0] {RUN = 2'd0, LU_STALL = 2'd1, MEM_WAIT = 2'd2, FLUSH = 2'd3} state_t;
  state_t state_q, state_d;
  logic [WW-1:0] wait_cnt, wait_nxt;
  logic use_rs1, use_rs2, hazard, memstall, br_eff, hz_eff;
  assign use_rs1  = !(IF_ID_OPCODE inside {7'h37, 7'h17, 7'h6f});
  assign use_rs2  = !(IF_ID_OPCODE inside {7'h03, 7'h13, 7'h1b, 7'h37, 7'h17, 7'h6f, 7'h67});
  assign hazard   = ID_EXE_MemRead && (ID_EXE_rd != 5'd0) &&
                    ((use_rs1 && ID_EXE_rd == IF_ID_rs1) || (use_rs2 && ID_EXE_rd == IF_ID_rs2));
  assign memstall = dmem_req && !dmem_ready;
  // FLUSH ignores the redirect that caused it; LU_STALL ignores the hazard it just resolved
  assign br_eff   = branch_taken && (state_q != FLUSH);
  assign hz_eff   = hazard && (state_q != LU_STALL);
  assign state    = state_q;
  assign wait_nxt = (state_q == MEM_WAIT && memstall) ?
                    ((wait_cnt == WW'(MEM_TIMEOUT)) ? wait_cnt : wait_cnt + 1'b1) : '0;
  // Priority: reset, memory stall, branch flush, load-use stall, normal flow
  always_comb begin
    state_d       = RUN;
    PC_Write      = 1'b1;
    IF_ID_Write   = 1'b1;
    IF_ID_Flush   = 1'b0;
    ID_EXE_Bubble = 1'b0;
    pipe_hold     = 1'b0;
    if (rst) begin
      PC_Write      = 1'b0;
      IF_ID_Write   = 1'b0;
      IF_ID_Flush   = 1'b1;
      ID_EXE_Bubble = 1'b1;
    end else if (memstall) begin
      state_d     = MEM_WAIT;
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      pipe_hold   = 1'b1;
    end else if (br_eff) begin
      state_d       = FLUSH;
      IF_ID_Flush   = 1'b1;
      ID_EXE_Bubble = 1'b1;
    end else if (hz_eff) begin
      state_d       = LU_STALL;
      PC_Write      = 1'b0;
      IF_ID_Write   = 1'b0;
      ID_EXE_Bubble = 1'b1;
    end
  end
  // State, memory-wait watchdog and saturating stall counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      wait_cnt    <= '0;
      stall_count <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_cnt <= wait_nxt;
      if (!PC_Write && stall_count != '1) stall_count <= stall_count + 1'b1;
      if (wait_nxt == WW'(MEM_TIMEOUT)) mem_timeout <= 1'b1;
    end
  end
endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 64: MEM_WAIT cycle count at which mem_timeout sets.
REQ-002 SHALL have parameter CNT_W, default 16: width of stall_count.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port ID_EXE_MemRead  input  1  instruction in EXE is a load.
REQ-007 SHALL have port ID_EXE_rd  input  5  EXE destination register.
REQ-008 SHALL have ports IF_ID_rs1, IF_ID_rs2  input  5 each  ID source registers.
REQ-009 SHALL have port IF_ID_OPCODE  input  7  ID opcode.
REQ-010 SHALL have port branch_taken  input  1  EXE branch/jump redirect.
REQ-011 SHALL have ports dmem_req, dmem_ready  input  1 each  MEM-stage data-memory request and completion.
REQ-012 SHALL have ports PC_Write, IF_ID_Write  output  1 each  PC and IF/ID register enables.
REQ-013 SHALL have ports IF_ID_Flush, ID_EXE_Bubble  output  1 each  zero IF/ID; inject NOP into ID/EXE.
REQ-014 SHALL have port pipe_hold  output  1  freeze ID/EXE, EXE/MEM and MEM/WB.
REQ-015 SHALL have port state  output  2  current state.
REQ-016 SHALL have ports stall_count  output  CNT_W; mem_timeout  output  1 (sticky).

Function
REQ-017 SHALL implement states RUN=0, LU_STALL=1, MEM_WAIT=2, FLUSH=3; state is registered, control outputs are combinational from state and inputs.
REQ-018 SHALL define use_rs1 as 0 for opcodes 0x37, 0x17, 0x6f, and 1 otherwise.
REQ-019 SHALL define use_rs2 as 0 for opcodes 0x03, 0x13, 0x1b, 0x37, 0x17, 0x6f, 0x67, and 1 otherwise.
REQ-020 SHALL define hazard as ID_EXE_MemRead, ID_EXE_rd!=0, and a match on either source: (use_rs1 and rd==rs1) or (use_rs2 and rd==rs2).
REQ-021 SHALL define memstall as dmem_req and !dmem_ready.
REQ-022 SHALL give memstall the highest priority in every state: pipe_hold=1, PC_Write=0, IF_ID_Write=0, IF_ID_Flush=0, ID_EXE_Bubble=0; next state MEM_WAIT.
REQ-023 SHALL, in RUN with branch_taken and !memstall, drive IF_ID_Flush=1, ID_EXE_Bubble=1, PC_Write=1, IF_ID_Write=1; next state FLUSH.
REQ-024 SHALL, in RUN with hazard, !branch_taken and !memstall, drive PC_Write=0, IF_ID_Write=0, ID_EXE_Bubble=1; next state LU_STALL.
REQ-025 SHALL otherwise drive PC_Write=1, IF_ID_Write=1, IF_ID_Flush=0, ID_EXE_Bubble=0, pipe_hold=0; next state RUN.
REQ-026 SHALL evaluate LU_STALL exactly as RUN with hazard masked to 0, so a load-use stall never exceeds one cycle.
REQ-027 SHALL evaluate FLUSH exactly as RUN with branch_taken masked to 0.
REQ-028 SHALL, in MEM_WAIT with dmem_ready=1, evaluate exactly as RUN, so a pending branch_taken or hazard is serviced in that same cycle.
REQ-029 SHALL count consecutive MEM_WAIT cycles and set mem_timeout when the count reaches MEM_TIMEOUT; mem_timeout clears only on reset, and the count clears on MEM_WAIT exit.
REQ-030 SHALL increment stall_count on each clock edge where PC_Write=0, saturating at all-ones.
REQ-031 SHALL treat dmem_req and dmem_ready both 1 in RUN as no stall.

Reset
REQ-032 SHALL, on rst assertion, immediately set state=RUN, stall_count=0, mem_timeout=0, and the wait counter to 0.
REQ-033 SHALL, while rst=1, force PC_Write=0, IF_ID_Write=0, IF_ID_Flush=1, ID_EXE_Bubble=1, pipe_hold=0, and not increment stall_count.
REQ-034 SHALL, on rst assertion mid-MEM_WAIT or mid-LU_STALL, abandon the stall with no residual hold after release.

Verification
REQ-035 SHALL cover load-use: MemRead=1, rd=5, ID rs1=5, opcode 0x33 -> one cycle with PC_Write=0 and Bubble=1, then state LU_STALL, then RUN; stall_count=1.
REQ-036 SHALL cover rs2 masking: MemRead=1, rd=7, rs2=7, rs1=3, opcode 0x13 -> no stall.
REQ-037 SHALL cover branch priority: branch_taken=1 and hazard=1 together -> IF_ID_Flush=1, Bubble=1, PC_Write=1; state goes to FLUSH, not LU_STALL.
REQ-038 SHALL cover memory wait: dmem_req=1 with dmem_ready low for 3 cycles -> pipe_hold=1 for 3 cycles, stall_count=3, RUN after ready.
REQ-039 SHALL cover exit with branch: dmem_ready and branch_taken rise together -> same-cycle flush, next state FLUSH.
REQ-040 SHALL cover timeout and reset: MEM_TIMEOUT=4, ready held low 6 cycles -> mem_timeout=1 stays set; rst pulse -> state=0, mem_timeout=0, stall_count=0.
